dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 34 +++
 rtl/dmem_arbiter.sv | 111 +++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bundle of requester, grant/read-return and memory-side signals for dmem_arbiter.
// The slave modport is the arbiter view; master is the requester/memory environment.
interface dmem_arbiter_if #(
    parameter int DBITS = 32
);
    logic             req0,    req1;
    logic             we0,     we1;
    logic             lock0,   lock1;
    logic [DBITS-1:0] addr0,   addr1;
    logic [DBITS-1:0] wdata0,  wdata1;
    logic             gnt0,    gnt1;
    logic             rvalid0, rvalid1;
    logic [DBITS-1:0] rdata0,  rdata1;
    logic             mem_we;
    logic [DBITS-1:0] mem_addr;
    logic [DBITS-1:0] mem_wdata;
    logic [DBITS-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1,
        input  addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req0, req1, we0, we1, lock0, lock1,
        output addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: round-robin on ties, optional bounded locking,
// single-cycle grant with read data returned one cycle after the address.
module dmem_arbiter #(
    parameter int DBITS    = 32,
    parameter int LOCK_MAX = 16
) (
    input logic          clk,
    input logic          reset,
    dmem_arbiter_if.slave bus
);
    localparam int CW = $clog2(LOCK_MAX + 1);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t           state_q;
    logic             last_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_inc;
    logic             rvalid0_q, rvalid1_q;
    logic [DBITS-1:0] rdata0_q,  rdata1_q;
    logic [DBITS-1:0] addr_q,    wdata_q;
    logic             gnt0, gnt1;
    logic             own_req, own_lock, oth_req;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.req0 && bus.req1) begin
                        gnt0 = last_q;
                        gnt1 = !last_q;
                    end else begin
                        gnt0 = bus.req0;
                        gnt1 = bus.req1;
                    end
                end
                LOCK0:   gnt0 = bus.req0;
                LOCK1:   gnt1 = bus.req1;
                default: ;
            endcase
        end
    end

    always_comb begin
        own_req  = (state_q == LOCK1) ? bus.req1  : bus.req0;
        own_lock = (state_q == LOCK1) ? bus.lock1 : bus.lock0;
        oth_req  = (state_q == LOCK1) ? bus.req0  : bus.req1;
        cnt_inc  = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            cnt_q     <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            rvalid0_q <= gnt0 && !bus.we0;
            rvalid1_q <= gnt1 && !bus.we1;
            if (rvalid0_q) rdata0_q <= bus.mem_rdata;
            if (rvalid1_q) rdata1_q <= bus.mem_rdata;
            if (gnt0 || gnt1) begin
                last_q  <= gnt1;
                addr_q  <= gnt1 ? bus.addr1  : bus.addr0;
                wdata_q <= gnt1 ? bus.wdata1 : bus.wdata0;
            end
            unique case (state_q)
                IDLE: begin
                    if (gnt0 && bus.lock0) begin
                        state_q <= LOCK0;
                        cnt_q   <= '0;
                    end else if (gnt1 && bus.lock1) begin
                        state_q <= LOCK1;
                        cnt_q   <= '0;
                    end
                end
                LOCK0, LOCK1: begin
                    // Hitting LOCK_MAX forces release; last already points at the owner.
                    if (!own_req) begin
                        state_q <= IDLE;
                    end else begin
                        if (oth_req) cnt_q <= cnt_inc;
                        if (!own_lock || (oth_req && cnt_inc == CW'(LOCK_MAX)))
                            state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Reset gates the outputs so a read outstanding at reset never surfaces.
    always_comb begin
        bus.gnt0      = gnt0;
        bus.gnt1      = gnt1;
        bus.mem_we    = (gnt0 && bus.we0) || (gnt1 && bus.we1);
        bus.mem_addr  = reset ? '0 : gnt1 ? bus.addr1  : gnt0 ? bus.addr0  : addr_q;
        bus.mem_wdata = reset ? '0 : gnt1 ? bus.wdata1 : gnt0 ? bus.wdata0 : wdata_q;
        bus.rvalid0   = rvalid0_q && !reset;
        bus.rvalid1   = rvalid1_q && !reset;
        bus.rdata0    = reset ? '0 : rvalid0_q ? bus.mem_rdata : rdata0_q;
        bus.rdata1    = reset ? '0 : rvalid1_q ? bus.mem_rdata : rdata1_q;
    end
endmodule
